// File: rtl/z80_int_controller.sv
// Prioritised IM2 interrupt controller: edge-latched requests, masking, nesting, vector on ack.
// Optional RETI opcode snoop (ED 4D acts as an EOI) is built when Z80_INTC_RETI_EN is defined.
module z80_int_controller #(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] PORT_BASE = 8'h30
) (
  input  logic               i_mclk,
  input  logic               i_reset_n,
  input  logic [NUM_SRC-1:0] i_irq,
  input  logic               i_m1_n,
  input  logic               i_iorq_n,
  input  logic               i_memrq_n,
  input  logic               i_rd_n,
  input  logic               i_wr_n,
  input  logic [7:0]         i_addr,
  input  logic [7:0]         i_data,
  output logic [7:0]         o_data,
  output logic               o_data_en,
  output logic               o_int_n
);

  localparam logic [NUM_SRC-1:0] SRC_ONE = NUM_SRC'(1);

  typedef enum logic {IDLE, ACK} ack_state_t;

  ack_state_t         state, state_nxt;
  logic [NUM_SRC-1:0] irq_s1, irq_s2, irq_s3, irq_rise;
  logic [NUM_SRC-1:0] mask, pend, insvc;
  logic [NUM_SRC-1:0] pend_nxt, insvc_nxt, insvc_eoi, win_onehot, ack_clr, w1c;
  logic [3:0]         vec_hi;
  logic [7:0]         vector, rd_data;
  logic [3:0]         wr_reg;
  logic [2:0]         win, code;
  logic               win_valid, blocked;
  logic               addr_hit, io_sel, wr_now, rd_now, wr_q, wr_pulse;
  logic               ack_cyc, ack_take, ack_real, eoi, reti_eoi, int_n_q, int_n_nxt;

  assign irq_rise = irq_s2 & ~irq_s3;

  // Bus decode; writes act only on the first cycle the strobe is seen.
  assign addr_hit = (i_addr[7:2] == PORT_BASE[7:2]);
  assign io_sel   = !i_iorq_n && i_m1_n && addr_hit;
  assign wr_now   = io_sel && !i_wr_n;
  assign rd_now   = io_sel && !i_rd_n;
  assign wr_pulse = wr_now && !wr_q;
  assign wr_reg   = wr_pulse ? (4'b0001 << i_addr[1:0]) : 4'b0000;
  assign ack_cyc  = !i_m1_n && !i_iorq_n;
  assign ack_take = (state == IDLE) && ack_cyc;

  // Lowest-index enabled pending source wins unless an equal or higher
  // priority source is already in service.
  always_comb begin
    // NOTE: every variable gets a default first so no latch can be inferred.
    win       = 3'd7;
    win_valid = 1'b0;
    blocked   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_valid && !blocked) begin
        if (insvc[i]) begin
          blocked = 1'b1;
        end else if (pend[i] && mask[i]) begin
          win       = 3'(i);
          win_valid = 1'b1;
        end
      end
    end
  end

  assign code       = win_valid ? win : 3'b111;
  assign ack_real   = ack_take && win_valid;
  assign win_onehot = SRC_ONE << win;
  assign ack_clr    = ack_real ? win_onehot : '0;
  assign w1c        = wr_reg[1] ? i_data[NUM_SRC-1:0] : '0;
  assign eoi        = wr_reg[3] || reti_eoi;

  // EOI retires the highest-priority in-service bit before the ack sets a new one.
  assign insvc_eoi = eoi ? (insvc & (insvc - SRC_ONE)) : insvc;
  assign insvc_nxt = insvc_eoi | ack_clr;
  assign pend_nxt  = (pend & ~w1c & ~ack_clr) | irq_rise;
  assign int_n_nxt = !((state == IDLE) && win_valid && !ack_cyc);

  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      irq_s1  <= '0;
      irq_s2  <= '0;
      irq_s3  <= '0;
      mask    <= '0;
      pend    <= '0;
      insvc   <= '0;
      vec_hi  <= '0;
      vector  <= '0;
      wr_q    <= 1'b0;
      int_n_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      irq_s1  <= i_irq;
      irq_s2  <= irq_s1;
      irq_s3  <= irq_s2;
      wr_q    <= wr_now;
      int_n_q <= int_n_nxt;
      pend    <= pend_nxt;
      insvc   <= insvc_nxt;
      if (wr_reg[0]) mask   <= i_data[NUM_SRC-1:0];
      if (wr_reg[2]) vec_hi <= i_data[7:4];
      if (ack_take)  vector <= {vec_hi, code, 1'b0};
    end
  end

  assign o_int_n = int_n_q;

  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ack_cyc)  state_nxt = ACK;
      ACK:  if (!ack_cyc) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    case (i_addr[1:0])
      2'd0: rd_data = 8'(mask);
      2'd1: rd_data = 8'(pend);
      2'd2: rd_data = {vec_hi, 4'h0};
      2'd3: rd_data = 8'(insvc);
    endcase
  end

  always_comb begin
    o_data    = 8'h00;
    o_data_en = 1'b0;
    if (state == ACK && ack_cyc) begin
      o_data    = vector;
      o_data_en = 1'b1;
    end else if (rd_now) begin
      o_data    = rd_data;
      o_data_en = 1'b1;
    end
  end

`ifdef Z80_INTC_RETI_EN
  typedef enum logic {S_IDLE, S_ED} snoop_t;

  snoop_t     snoop_q, snoop_nxt;
  logic       fetch_now, fetch_q;
  logic [7:0] op_q;

  // The opcode is judged on the cycle after the fetch ends, using the last sampled byte.
  assign fetch_now = !i_m1_n && !i_memrq_n && !i_rd_n;

  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      snoop_q <= S_IDLE;
      fetch_q <= 1'b0;
      op_q    <= 8'h00;
    end else begin
      snoop_q <= snoop_nxt;
      fetch_q <= fetch_now;
      if (fetch_now) op_q <= i_data;
    end
  end

  always_comb begin
    snoop_nxt = snoop_q;
    reti_eoi  = 1'b0;
    if (fetch_q && !fetch_now) begin
      if (op_q == 8'hED) begin
        snoop_nxt = S_ED;
      end else begin
        reti_eoi  = (snoop_q == S_ED) && (op_q == 8'h4D);
        snoop_nxt = S_IDLE;
      end
    end
  end
`else
  logic unused_memrq;
  assign reti_eoi     = 1'b0;
  assign unused_memrq = &{1'b0, i_memrq_n};
`endif

endmodule

// File: tb/tb_z80_int_controller.sv
// Scoreboard bench for z80_int_controller: expectations queued with stimulus, compared as observed.
// Define Z80_INTC_RETI_EN to include the RETI snoop scenario.
module tb_z80_int_controller;

  localparam logic [7:0] BASE = 8'h30;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  logic       mclk = 1'b0, reset_n = 1'b0;
  logic [3:0] irq = '0;
  logic       m1_n = 1'b1, iorq_n = 1'b1, memrq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0] addr = 8'h00, data_in = 8'h00;
  logic [7:0] o_data;
  logic       o_data_en, o_int_n;

  exp_t       sb[$];
  logic [7:0] got[$];
  int         n_checks = 0, n_pass = 0;

  z80_int_controller #(.NUM_SRC(4), .PORT_BASE(BASE)) dut (
    .i_mclk(mclk), .i_reset_n(reset_n), .i_irq(irq), .i_m1_n(m1_n), .i_iorq_n(iorq_n),
    .i_memrq_n(memrq_n), .i_rd_n(rd_n), .i_wr_n(wr_n), .i_addr(addr), .i_data(data_in),
    .o_data(o_data), .o_data_en(o_data_en), .o_int_n(o_int_n)
  );

  always #5 mclk = ~mclk;

  task automatic expect_val(input string n, input logic [7:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic io_write(input logic [1:0] off, input logic [7:0] d);
    @(negedge mclk);
    addr = {BASE[7:2], off}; data_in = d; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge mclk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge mclk);
  endtask

  task automatic io_read(input logic [1:0] off, output logic [7:0] d);
    @(negedge mclk);
    addr = {BASE[7:2], off}; iorq_n = 1'b0; rd_n = 1'b0;
    #2 d = o_data;
    @(negedge mclk);
    iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic pulse_irq(input int idx);
    @(negedge mclk) irq[idx] = 1'b1;
    repeat (3) @(negedge mclk);
    irq[idx] = 1'b0;
  endtask

  task automatic wait_int(input logic lvl, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge mclk);
      if (o_int_n === lvl) break;
    end
  endtask

  task automatic do_ack(output logic [7:0] vec, output logic en, output logic int_n);
    @(negedge mclk) m1_n = 1'b0;
    @(negedge mclk) iorq_n = 1'b0;
    @(negedge mclk);
    vec = o_data; en = o_data_en; int_n = o_int_n;
    iorq_n = 1'b1; m1_n = 1'b1;
    @(negedge mclk);
  endtask

  task automatic fetch(input logic [7:0] op);
    @(negedge mclk);
    m1_n = 1'b0; memrq_n = 1'b0; rd_n = 1'b0; data_in = op;
    repeat (2) @(negedge mclk);
    m1_n = 1'b1; memrq_n = 1'b1; rd_n = 1'b1;
    @(negedge mclk);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    exp_t e;
    logic [7:0] g;
    repeat (2) @(negedge mclk);
    expect_val("por_int_n", 8'h01);   got.push_back({7'b0, o_int_n});
    expect_val("por_data_en", 8'h00); got.push_back({7'b0, o_data_en});
    reset_n = 1'b1;
    io_write(2'd0, 8'h02);
    io_write(2'd2, 8'hA0);
    pulse_irq(1);
    wait_int(1'b0, 8);
    @(negedge mclk) begin m1_n = 1'b0; iorq_n = 1'b0; end
    @(negedge mclk);
    expect_val("mid_ack_en", 8'h01);   got.push_back({7'b0, o_data_en});
    #1 reset_n = 1'b0;
    #1;
    expect_val("abort_int_n", 8'h01);  got.push_back({7'b0, o_int_n});
    expect_val("abort_en", 8'h00);     got.push_back({7'b0, o_data_en});
    @(negedge mclk) begin m1_n = 1'b1; iorq_n = 1'b1; end
    @(negedge mclk) reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_val($sformatf("rst_reg%0d", k), 8'h00);
      io_read(2'(k), d);
      got.push_back(d);
    end
    while (got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_checks++;
      if (g !== e.val) $display("FAIL %s: got %h, expected %h", e.name, g, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_irq_ack;
    logic [7:0] d, vec;
    logic en, ia;
    exp_t e;
    logic [7:0] g;
    io_write(2'd0, 8'h02);
    io_write(2'd2, 8'hA0);
    @(negedge mclk) irq[1] = 1'b1;
    expect_val("t2_int_low_4cyc", 8'h00);
    wait_int(1'b0, 4);
    got.push_back({7'b0, o_int_n});
    irq[1] = 1'b0;
    expect_val("t2_vector", 8'hA2);
    expect_val("t2_ack_en", 8'h01);
    expect_val("t2_int_released", 8'h01);
    do_ack(vec, en, ia);
    got.push_back(vec); got.push_back({7'b0, en}); got.push_back({7'b0, ia});
    expect_val("t2_pend", 8'h00);  io_read(2'd1, d); got.push_back(d);
    expect_val("t2_insvc", 8'h02); io_read(2'd3, d); got.push_back(d);
    io_write(2'd3, 8'h00);
    expect_val("t2_eoi", 8'h00);   io_read(2'd3, d); got.push_back(d);
    while (got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_checks++;
      if (g !== e.val) $display("FAIL %s: got %h, expected %h", e.name, g, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_nesting;
    logic [7:0] d, vec;
    logic en, ia;
    exp_t e;
    logic [7:0] g;
    io_write(2'd0, 8'h0F);
    pulse_irq(2);
    wait_int(1'b0, 8);
    expect_val("t3_vec2", 8'hA4);
    do_ack(vec, en, ia); got.push_back(vec);
    pulse_irq(3);
    repeat (8) @(negedge mclk);
    expect_val("t3_irq3_blocked", 8'h01); got.push_back({7'b0, o_int_n});
    expect_val("t3_pend3", 8'h08);        io_read(2'd1, d); got.push_back(d);
    pulse_irq(0);
    expect_val("t3_irq0_int", 8'h00);
    wait_int(1'b0, 8); got.push_back({7'b0, o_int_n});
    expect_val("t3_vec0", 8'hA0);
    do_ack(vec, en, ia); got.push_back(vec);
    expect_val("t3_insvc_nested", 8'h05); io_read(2'd3, d); got.push_back(d);
    io_write(2'd3, 8'h00);
    expect_val("t3_insvc_eoi", 8'h04);    io_read(2'd3, d); got.push_back(d);
    expect_val("t3_still_blocked", 8'h01); got.push_back({7'b0, o_int_n});
    io_write(2'd3, 8'h00);
    expect_val("t3_irq3_released", 8'h00);
    wait_int(1'b0, 8); got.push_back({7'b0, o_int_n});
    expect_val("t3_vec3", 8'hA6);
    do_ack(vec, en, ia); got.push_back(vec);
    io_write(2'd3, 8'h00);
    expect_val("t3_insvc_clear", 8'h00);  io_read(2'd3, d); got.push_back(d);
    while (got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_checks++;
      if (g !== e.val) $display("FAIL %s: got %h, expected %h", e.name, g, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_spurious;
    logic [7:0] d, vec;
    logic en, ia;
    exp_t e;
    logic [7:0] g;
    io_write(2'd0, 8'h00);
    pulse_irq(0);
    repeat (4) @(negedge mclk);
    expect_val("t4_pend_latched", 8'h01); io_read(2'd1, d); got.push_back(d);
    expect_val("t4_int_idle", 8'h01);     got.push_back({7'b0, o_int_n});
    expect_val("t4_vector", 8'hAE);
    expect_val("t4_ack_en", 8'h01);
    do_ack(vec, en, ia); got.push_back(vec); got.push_back({7'b0, en});
    expect_val("t4_pend_kept", 8'h01);    io_read(2'd1, d); got.push_back(d);
    expect_val("t4_insvc_kept", 8'h00);   io_read(2'd3, d); got.push_back(d);
    io_write(2'd1, 8'h01);
    expect_val("t4_w1c", 8'h00);          io_read(2'd1, d); got.push_back(d);
    while (got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_checks++;
      if (g !== e.val) $display("FAIL %s: got %h, expected %h", e.name, g, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_masked_latch;
    logic [7:0] d;
    exp_t e;
    logic [7:0] g;
    io_write(2'd0, 8'h00);
    pulse_irq(2);
    repeat (4) @(negedge mclk);
    expect_val("t5_pend", 8'h04);      io_read(2'd1, d); got.push_back(d);
    expect_val("t5_int_masked", 8'h01); got.push_back({7'b0, o_int_n});
    io_write(2'd0, 8'h04);
    expect_val("t5_int_unmasked", 8'h00);
    wait_int(1'b0, 4); got.push_back({7'b0, o_int_n});
    io_write(2'd1, 8'h04);
    expect_val("t5_int_after_w1c", 8'h01);
    wait_int(1'b1, 4); got.push_back({7'b0, o_int_n});
    expect_val("t5_pend_clear", 8'h00); io_read(2'd1, d); got.push_back(d);
    while (got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_checks++;
      if (g !== e.val) $display("FAIL %s: got %h, expected %h", e.name, g, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_registers;
    logic [7:0] d;
    exp_t e;
    logic [7:0] g;
    io_write(2'd0, 8'hFF);
    expect_val("mask_unused_bits", 8'h0F); io_read(2'd0, d); got.push_back(d);
    io_write(2'd2, 8'h5B);
    expect_val("vec_low_nibble", 8'h50);   io_read(2'd2, d); got.push_back(d);
    io_write(2'd3, 8'h00);
    expect_val("eoi_when_idle", 8'h00);    io_read(2'd3, d); got.push_back(d);
    io_write(2'd2, 8'hA0);
    io_write(2'd0, 8'h00);
    expect_val("mask_cleared", 8'h00);     io_read(2'd0, d); got.push_back(d);
    while (got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_checks++;
      if (g !== e.val) $display("FAIL %s: got %h, expected %h", e.name, g, e.val);
      else n_pass++;
    end
  endtask

`ifdef Z80_INTC_RETI_EN
  task automatic test_reti;
    logic [7:0] d, vec;
    logic en, ia;
    exp_t e;
    logic [7:0] g;
    io_write(2'd0, 8'h02);
    pulse_irq(1);
    wait_int(1'b0, 8);
    do_ack(vec, en, ia);
    expect_val("t6_insvc_set", 8'h02);   io_read(2'd3, d); got.push_back(d);
    fetch(8'hED);
    fetch(8'h4D);
    expect_val("t6_reti_eoi", 8'h00);    io_read(2'd3, d); got.push_back(d);
    pulse_irq(1);
    wait_int(1'b0, 8);
    do_ack(vec, en, ia);
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    expect_val("t6_broken_reti", 8'h02); io_read(2'd3, d); got.push_back(d);
    io_write(2'd3, 8'h00);
    while (got.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); n_checks++;
      if (g !== e.val) $display("FAIL %s: got %h, expected %h", e.name, g, e.val);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_irq_ack();
    test_nesting();
    test_spurious();
    test_masked_latch();
    test_registers();
`ifdef Z80_INTC_RETI_EN
    test_reti();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
